// File: rtl/button_reader.sv
// ---------------------------------------------------------------------------
// ButtonReader (top: button_reader)
//
// Debounced push-button reader. The raw board button is brought into the
// clock domain through a two-flop synchroniser and normalised so that 1 means
// pressed. A four-state machine then accepts a level change only after it has
// been seen for DEBOUNCE_CYCLES consecutive sampled cycles.
//
// Ports:
//   CLOCK_IN      in   sole clock, rising edge
//   RESET         in   synchronous, active-high reset
//   BUTTON_IN     in   raw asynchronous button pin
//   BUTTON_STATE  out  debounced level, 1 = pressed
//   PRESS_PULSE   out  one-cycle pulse on an accepted press
//   RELEASE_PULSE out  one-cycle pulse on an accepted release
//   LONG_PRESS    out  one-cycle pulse, at most once per press
//   PRESS_COUNT   out  accepted presses, wrapping modulo 2^COUNT_WIDTH
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module button_reader #(
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter int unsigned LONG_PRESS_CYCLES = 50000000,
   parameter int unsigned COUNT_WIDTH       = 8,
   parameter bit          ACTIVE_LOW        = 1'b1
) (
   input  logic                   CLOCK_IN,
   input  logic                   RESET,
   input  logic                   BUTTON_IN,
   output logic                   BUTTON_STATE,
   output logic                   PRESS_PULSE,
   output logic                   RELEASE_PULSE,
   output logic                   LONG_PRESS,
   output logic [COUNT_WIDTH-1:0] PRESS_COUNT
);

   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DCNT_W-1:0] DCNT_ZERO = '0;
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } stateT;

   stateT                  state_q, state_d;
   logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   syncMeta_q, syncOut_q;
   logic                   buttonState_q, buttonState_d;
   logic                   pressPulse_q, pressPulse_d;
   logic                   releasePulse_q, releasePulse_d;
   logic                   longPress_q, longPress_d;
   logic [COUNT_WIDTH-1:0] pressCount_q, pressCount_d;

   logic pinPressed;
   logic sample;

   // Polarity is normalised ahead of the synchroniser (a constant XOR is a
   // plain inverter or wire) so that the reset value 0 of both flops means
   // "released" for either button polarity.
   assign pinPressed = BUTTON_IN ^ ACTIVE_LOW;
   assign sample     = syncOut_q;

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge CLOCK_IN) begin
      if (RESET) begin
         syncMeta_q <= 1'b0;
         syncOut_q  <= 1'b0;
      end else begin
         syncMeta_q <= pinPressed;
         syncOut_q  <= syncMeta_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLOCK_IN) begin
      if (RESET) begin
         state_q        <= RELEASED;
         dcnt_q         <= DCNT_ZERO;
         hold_q         <= '0;
         buttonState_q  <= 1'b0;
         pressPulse_q   <= 1'b0;
         releasePulse_q <= 1'b0;
         longPress_q    <= 1'b0;
         pressCount_q   <= '0;
      end else begin
         state_q        <= state_d;
         dcnt_q         <= dcnt_d;
         hold_q         <= hold_d;
         buttonState_q  <= buttonState_d;
         pressPulse_q   <= pressPulse_d;
         releasePulse_q <= releasePulse_d;
         longPress_q    <= longPress_d;
         pressCount_q   <= pressCount_d;
      end
   end

   // Next-state logic. The hold counter keeps running through RELEASE_WAIT so
   // a short release glitch does not disturb long-press timing; an accepted
   // release on the same edge as the long-press threshold suppresses the
   // long-press pulse.
   always_comb begin
      state_d        = state_q;
      dcnt_d         = dcnt_q;
      hold_d         = hold_q;
      buttonState_d  = buttonState_q;
      pressPulse_d   = 1'b0;
      releasePulse_d = 1'b0;
      longPress_d    = 1'b0;
      pressCount_d   = pressCount_q;

      if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_q != HOLD_MAX) begin
         hold_d      = hold_q + HOLD_W'(1);
         longPress_d = (hold_q == HOLD_PRE);
      end

      case (state_q)
         RELEASED: begin
            if (sample) begin
               state_d = PRESS_WAIT;
               dcnt_d  = DCNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!sample) begin
               state_d = RELEASED;
               dcnt_d  = DCNT_ZERO;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d       = PRESSED;
               dcnt_d        = DCNT_ZERO;
               pressPulse_d  = 1'b1;
               buttonState_d = 1'b1;
               pressCount_d  = pressCount_q + COUNT_WIDTH'(1);
               hold_d        = '0;
            end else begin
               dcnt_d = dcnt_q + DCNT_ONE;
            end
         end
         PRESSED: begin
            if (!sample) begin
               state_d = RELEASE_WAIT;
               dcnt_d  = DCNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (sample) begin
               state_d = PRESSED;
               dcnt_d  = DCNT_ZERO;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d        = RELEASED;
               dcnt_d         = DCNT_ZERO;
               releasePulse_d = 1'b1;
               buttonState_d  = 1'b0;
               longPress_d    = 1'b0;
            end else begin
               dcnt_d = dcnt_q + DCNT_ONE;
            end
         end
         default: begin
            state_d = RELEASED;
            dcnt_d  = DCNT_ZERO;
         end
      endcase
   end

   assign BUTTON_STATE  = buttonState_q;
   assign PRESS_PULSE   = pressPulse_q;
   assign RELEASE_PULSE = releasePulse_q;
   assign LONG_PRESS    = longPress_q;
   assign PRESS_COUNT   = pressCount_q;

endmodule
